instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumes the next-PC value produced by the branch/next-PC stage and fetches the instruction word at that address from instruction memory over a req/ack interface.
- Presents the fetched word and its PC to the decode stage through a valid/ready handshake.
- Sits between the next-PC logic and decode. Supports flush on redirect, a fetch timeout with a sticky error flag, and a delivered-instruction counter.
- PC is a word address; sequential PCs differ by 1.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address
- DATA_W, 32, width of an instruction word
- TIMEOUT, 16, cycles in REQ without imem_ack before abort (valid range 2..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_in  in  ADDR_W  next PC from branch stage
- pc_in_valid  in  1  pc_in is valid this cycle
- pc_in_ready  out  1  fetch unit accepts pc_in this cycle (combinational)
- flush  in  1  discard in-flight/held instruction (branch redirect)
- imem_req  out  1  instruction memory request (registered)
- imem_addr  out  ADDR_W  request address (registered, stable while imem_req=1)
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  DATA_W  instruction word, valid when imem_ack=1
- instr_valid  out  1  instr_out/instr_pc valid toward decode
- instr_ready  in  1  decode accepts the instruction
- instr_out  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  PC of instr_out
- fetch_err  out  1  sticky timeout error
- fetch_count  out  32  count of instructions delivered to decode; wraps at 2^32

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all registered outputs 0 (imem_req, imem_addr, instr_valid, instr_out, instr_pc, fetch_err, fetch_count); discard flag 0; timeout counter 0. rst mid-request drops the request. Any later imem_ack is ignored in IDLE.
- States: IDLE, REQ, HOLD.
- IDLE:
  - pc_in_ready = ~flush.
  - On pc_in_valid & pc_in_ready: imem_addr<=pc_in, imem_req<=1, counter<=0, go REQ.
- REQ:
  - pc_in_ready=0. imem_req held at 1 with a stable address until ack or timeout.
  - imem_ack & ~discard: instr_out<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0, go HOLD.
  - imem_ack & discard: drop data, imem_req<=0, discard<=0, go IDLE.
  - No ack: counter increments. When counter==TIMEOUT-1 and no ack: fetch_err<=1, imem_req<=0, discard<=0, go IDLE.
  - An ack in the timeout cycle wins over the timeout.
- HOLD:
  - instr_valid=1; pc_in_ready = instr_ready & ~flush.
  - instr_ready: fetch_count<=fetch_count+1, instr_valid<=0.
    - If pc_in_valid also: launch the next request in the same cycle (imem_addr<=pc_in, imem_req<=1, go REQ). This gives zero-bubble back-to-back fetch.
    - Otherwise go IDLE.
  - ~instr_ready: hold instr_out/instr_pc/instr_valid unchanged.
- Flush (priority over all other inputs except rst):
  - IDLE: no state change; pc_in not accepted that cycle.
  - REQ: discard<=1; the request is not withdrawn. Stay in REQ until ack or timeout, then go IDLE with no instr_valid.
  - HOLD: instr_valid<=0, go IDLE, fetch_count unchanged, even if instr_ready=1 that cycle.
- Latency: pc_in accepted at edge N → imem_req high from N+1; ack at cycle M → instr_valid high from M+1. Minimum pc_in→instr_valid is 2 cycles with same-cycle ack.
- fetch_err is cleared only by rst; fetching continues normally after an error.
- imem_ack outside REQ is ignored.

Decomposition:
- Shared package (cpu_pkg): state enum {IDLE, REQ, HOLD}; constant NOP_WORD for a flushed instr_out (instr_out is not required to change on flush); timeout counter width constant (8 bits).
- No sub-module needed. The timeout counter stays inline.

Test Plan:
- Reset, then pc_in=0x10 valid, mem acks 1 cycle after req with 0xDEADBEEF, instr_ready=1 → imem_addr=0x10; instr_out=0xDEADBEEF, instr_pc=0x10 for exactly 1 cycle; fetch_count=1.
- Back-to-back: pc_in 0x20,0x21,0x22 always valid, ack same cycle as req, instr_ready=1 → three instructions in consecutive HOLD/REQ alternation, instr_pc 0x20,0x21,0x22, fetch_count=3, no IDLE cycle between.
- Backpressure: instr_ready=0 for 5 cycles in HOLD → instr_out/instr_pc stable, pc_in_ready=0, fetch_count unchanged; release → count+1.
- Flush in REQ at cycle 2, ack at cycle 4 with 0x1234 → no instr_valid pulse, state IDLE, fetch_count unchanged; next pc_in 0x40 fetches normally.
- Timeout: req with no ack for TIMEOUT=16 cycles → imem_req drops after 16 cycles of assertion, fetch_err=1 and stays 1 until rst; a later ack is ignored.
- Flush with instr_ready=1 in HOLD, plus rst asserted in REQ → fetch_count not incremented; after rst all outputs 0, imem_req=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int unsigned TMO_CNT_W = 8;
    localparam int unsigned CNT_W     = 32;

    // Canonical RISC-V NOP (addi x0,x0,0), parked in instr_out when a held word is flushed
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle: next-PC input, instruction-memory req/ack bus and decode valid/ready output.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              pc_in_valid;
    logic              pc_in_ready;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        input  pc_in, pc_in_valid, flush, imem_ack, imem_rdata, instr_ready,
        output pc_in_ready, imem_req, imem_addr, instr_valid, instr_out, instr_pc
    );

    modport slave (
        output pc_in, pc_in_valid, flush, imem_ack, imem_rdata, instr_ready,
        input  pc_in_ready, imem_req, imem_addr, instr_valid, instr_out, instr_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetches one instruction word per accepted PC over req/ack and hands it to decode via valid/ready.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_unit_if.master   bus,
    output logic                 fetch_err,
    output logic [CNT_W-1:0]     fetch_count
);

    fetch_state_e          state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     out_q, out_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  discard_q, discard_d;
    logic [TMO_CNT_W-1:0]  tmo_q, tmo_d;
    logic                  ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            out_q     <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
            count_q   <= '0;
            discard_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            count_q   <= count_d;
            discard_q <= discard_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        out_d     = out_q;
        pc_d      = pc_q;
        err_d     = err_q;
        count_d   = count_q;
        discard_d = discard_q;
        tmo_d     = tmo_q;
        ready     = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready = ~bus.flush;
                if (bus.pc_in_valid && ready) begin
                    addr_d  = bus.pc_in;
                    req_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = REQ;
                end
            end

            REQ: begin
                // Ack beats timeout; a flush arriving with the ack still discards the word
                if (bus.imem_ack) begin
                    req_d     = 1'b0;
                    discard_d = 1'b0;
                    if (discard_q || bus.flush) begin
                        state_d = IDLE;
                    end else begin
                        out_d   = bus.imem_rdata;
                        pc_d    = addr_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (tmo_q == TMO_CNT_W'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    req_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    tmo_d     = tmo_q + TMO_CNT_W'(1);
                    discard_d = discard_q | bus.flush;
                end
            end

            HOLD: begin
                ready = bus.instr_ready & ~bus.flush;
                if (bus.flush) begin
                    valid_d = 1'b0;
                    out_d   = DATA_W'(NOP_WORD);
                    state_d = IDLE;
                end else if (bus.instr_ready) begin
                    count_d = count_q + CNT_W'(1);
                    valid_d = 1'b0;
                    // Launch the next fetch on the same edge the held word leaves
                    if (bus.pc_in_valid) begin
                        addr_d  = bus.pc_in;
                        req_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.pc_in_ready = ready;
    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_out   = out_q;
    assign bus.instr_pc    = pc_q;
    assign fetch_err       = err_q;
    assign fetch_count     = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: transaction model predicts delivered words, monitor checks them.
module tb_instr_fetch_unit;

    localparam int unsigned TIMEOUT = 16;

    typedef enum {M_IDLE, M_REQ, M_HOLD} mphase_e;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        fetch_err;
    logic [31:0] fetch_count;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    mphase_e     m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_data;
    int          m_wait;
    int          m_delay;
    bit          m_disc;
    bit          m_err;
    logic [31:0] m_count;
    exp_t        exp_q[$];

    // Parameters of the next accepted request
    int          next_delay;
    logic [31:0] next_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a new word is presented to decode
    initial begin : monitor
        bit   holding;
        exp_t cur;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                holding = 1'b0;
            end else if (ifc.instr_valid === 1'b1) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL instr_unexpected: got pc 0x%08h data 0x%08h expected no word at %0t",
                                 ifc.instr_pc, ifc.instr_out, $time);
                        cur.pc   = ifc.instr_pc;
                        cur.data = ifc.instr_out;
                    end else begin
                        cur = exp_q.pop_front();
                        check("instr_pc", ifc.instr_pc, cur.pc);
                        check("instr_out", ifc.instr_out, cur.data);
                    end
                    holding = 1'b1;
                end else begin
                    check("instr_pc_hold", ifc.instr_pc, cur.pc);
                    check("instr_out_hold", ifc.instr_out, cur.data);
                end
                if (ifc.instr_ready || ifc.flush) holding = 1'b0;
            end else begin
                holding = 1'b0;
            end
        end
    end

    // Called just after a negedge; applies rst across one rising edge and checks the cleared outputs
    task automatic do_reset();
        rst             = 1'b1;
        ifc.pc_in       = '0;
        ifc.pc_in_valid = 1'b0;
        ifc.flush       = 1'b0;
        ifc.instr_ready = 1'b0;
        ifc.imem_ack    = 1'b0;
        ifc.imem_rdata  = '0;
        @(negedge clk);
        rst     = 1'b0;
        m_phase = M_IDLE;
        m_disc  = 1'b0;
        m_err   = 1'b0;
        m_count = '0;
        exp_q.delete();
        check("rst_imem_req", 32'(ifc.imem_req), 32'd0);
        check("rst_imem_addr", ifc.imem_addr, 32'd0);
        check("rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
        check("rst_instr_out", ifc.instr_out, 32'd0);
        check("rst_instr_pc", ifc.instr_pc, 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
    endtask

    // One clock cycle: check registered outputs, drive inputs, check ready, advance the model
    task automatic cycle(input bit pv, input logic [31:0] pc, input bit fl, input bit rdy,
                         input bit spur, output bit acc);
        bit ack;
        bit exp_rdy;
        check("imem_req", 32'(ifc.imem_req), 32'(m_phase == M_REQ));
        if (m_phase == M_REQ) check("imem_addr", ifc.imem_addr, m_pc);
        check("instr_valid", 32'(ifc.instr_valid), 32'(m_phase == M_HOLD));
        check("fetch_err", 32'(fetch_err), 32'(m_err));
        check("fetch_count", fetch_count, m_count);

        ack = (m_phase == M_REQ) ? (m_wait == m_delay) : spur;
        ifc.pc_in_valid = pv;
        ifc.pc_in       = pc;
        ifc.flush       = fl;
        ifc.instr_ready = rdy;
        ifc.imem_ack    = ack;
        ifc.imem_rdata  = (m_phase == M_REQ) ? m_data : $urandom;
        #1;
        case (m_phase)
            M_IDLE:  exp_rdy = !fl;
            M_HOLD:  exp_rdy = rdy && !fl;
            default: exp_rdy = 1'b0;
        endcase
        check("pc_in_ready", 32'(ifc.pc_in_ready), 32'(exp_rdy));
        acc = pv && exp_rdy;

        case (m_phase)
            M_REQ: begin
                if (ack) begin
                    if (m_disc || fl) begin
                        m_phase = M_IDLE;
                    end else begin
                        exp_q.push_back('{pc: m_pc, data: m_data});
                        m_phase = M_HOLD;
                    end
                    m_disc = 1'b0;
                end else if (m_wait == TIMEOUT - 1) begin
                    m_err   = 1'b1;
                    m_disc  = 1'b0;
                    m_phase = M_IDLE;
                end else begin
                    m_wait++;
                    m_disc = m_disc || fl;
                end
            end
            M_HOLD: begin
                if (fl) m_phase = M_IDLE;
                else if (rdy) begin
                    m_count = m_count + 32'd1;
                    m_phase = M_IDLE;
                end
            end
            default: ;
        endcase
        if (acc) begin
            m_phase = M_REQ;
            m_pc    = pc;
            m_data  = next_data;
            m_delay = next_delay;
            m_wait  = 0;
        end
        @(negedge clk);
    endtask

    initial begin : stimulus
        bit          acc;
        logic [31:0] rpc;
        int          r;

        rst = 1'b1;
        next_delay = 0;
        next_data  = '0;
        @(negedge clk);
        do_reset();

        // Single fetch, ack one cycle after req
        next_delay = 1; next_data = 32'hDEAD_BEEF;
        cycle(1, 32'h10, 0, 1, 0, acc);
        for (int i = 0; i < 5; i++) cycle(0, 32'h0, 0, 1, 0, acc);

        // Back-to-back with same-cycle ack: HOLD/REQ alternation, no idle gap
        rpc = 32'h20;
        next_delay = 0;
        for (int i = 0; i < 12 && rpc < 32'h23; i++) begin
            next_data = 32'hA000_0000 | rpc;
            cycle(1, rpc, 0, 1, 0, acc);
            if (acc) rpc++;
        end
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 0, 1, 0, acc);

        // Backpressure for five cycles in HOLD
        next_delay = 0; next_data = 32'h3333_0030;
        cycle(1, 32'h30, 0, 0, 0, acc);
        cycle(0, 32'h0, 0, 0, 0, acc);
        for (int i = 0; i < 5; i++) cycle(1, 32'h31, 0, 0, 0, acc);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 1, 0, acc);

        // Flush during REQ, late ack is dropped; next fetch is normal
        next_delay = 3; next_data = 32'h0000_1234;
        cycle(1, 32'h38, 0, 1, 0, acc);
        cycle(0, 32'h0, 0, 1, 0, acc);
        cycle(0, 32'h0, 1, 1, 0, acc);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 0, 1, 0, acc);
        next_delay = 1; next_data = 32'h4444_0040;
        cycle(1, 32'h40, 0, 1, 0, acc);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 0, 1, 0, acc);

        // Timeout, then stray acks in IDLE, then normal fetch with sticky error
        next_delay = 99; next_data = 32'h5555_0050;
        cycle(1, 32'h50, 0, 1, 0, acc);
        for (int i = 0; i < TIMEOUT + 2; i++) cycle(0, 32'h0, 0, 1, 0, acc);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 1, 1, acc);
        next_delay = 0; next_data = 32'h6666_0060;
        cycle(1, 32'h60, 0, 1, 0, acc);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 1, 0, acc);

        // Flush with instr_ready in HOLD, then reset while a request is pending
        next_delay = 0; next_data = 32'h7777_0070;
        cycle(1, 32'h70, 0, 0, 0, acc);
        cycle(0, 32'h0, 0, 0, 0, acc);
        cycle(1, 32'h71, 1, 1, 0, acc);
        cycle(0, 32'h0, 0, 1, 0, acc);
        next_delay = 99;
        cycle(1, 32'h80, 0, 1, 0, acc);
        cycle(0, 32'h0, 0, 1, 0, acc);
        do_reset();
        for (int i = 0; i < 2; i++) cycle(0, 32'h0, 0, 1, 1, acc);

        // Randomized traffic against the model
        rpc = $urandom;
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 39);
            next_delay = (r < 30) ? (r % 5) : (r < 33) ? (TIMEOUT - 1) : (r < 35) ? TIMEOUT : (r < 36) ? 40 : 2;
            next_data  = $urandom;
            cycle($urandom_range(0, 9) < 7, rpc, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, acc);
            if (acc) rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom) : rpc + 32'd1;
            if (k == 1000) do_reset();
        end

        // Drain and confirm every predicted word was seen
        for (int i = 0; i < TIMEOUT + 4; i++) cycle(0, 32'h0, 0, 1, 0, acc);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
